// File: rtl/lsu_mem_initiator.sv
// Load/store unit for a byte-addressed doubleword memory: sized loads, RMW sub-doubleword stores, faults.
// Optional performance counters are enabled with `define LSU_PERF_EN.
module lsu_mem_initiator #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic [63:0] address,
  output logic [63:0] write_data,
  output logic        memorywrite,
  output logic        memoryread,
  input  logic [63:0] read_data
`ifdef LSU_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_faults
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_READ,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [60:0] LAST_DW = 61'(MEM_BYTES / 8 - 1);

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] data_q, data_d;
  logic        fault_q, fault_d;

  logic [63:0] base;
  logic [5:0]  shamt;
  logic [63:0] size_mask;
  logic [63:0] lane_mask;
  logic [63:0] shifted;
  logic [63:0] load_ext;
  logic [63:0] merged;
  logic        req_illegal;
  logic        req_misaligned;
  logic        req_oor;
  logic        req_fault;

  always_comb begin
    base      = {addr_q[63:3], 3'b000};
    shamt     = {addr_q[2:0], 3'b000};
    case (funct3_q[1:0])
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    lane_mask = size_mask << shamt;
    shifted   = read_data >> shamt;
    case (funct3_q)
      3'b000:  load_ext = {{56{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  load_ext = {56'd0, shifted[7:0]};
      3'b101:  load_ext = {48'd0, shifted[15:0]};
      3'b110:  load_ext = {32'd0, shifted[31:0]};
      default: load_ext = shifted;
    endcase
    // Only the addressed lanes come from the store data; the rest keep memory contents.
    merged = (read_data & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
  end

  always_comb begin
    req_illegal = (req_funct3 == 3'b111) || (req_write && req_funct3[2]);
    case (req_funct3[1:0])
      2'b00:   req_misaligned = 1'b0;
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = |req_addr[1:0];
      default: req_misaligned = |req_addr[2:0];
    endcase
    req_oor   = req_addr[63:3] > LAST_DW;
    req_fault = req_illegal || req_misaligned || req_oor;
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    fault_d     = fault_q;
    req_ready   = (state_q == S_IDLE) && reset_n;
    resp_valid  = 1'b0;
    resp_rdata  = 64'd0;
    resp_fault  = 1'b0;
    address     = 64'd0;
    write_data  = 64'd0;
    memoryread  = 1'b0;
    memorywrite = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          fault_d  = req_fault;
          data_d   = (req_write && !req_fault) ? req_wdata : 64'd0;
          if (req_fault)                   state_d = S_RESP;
          else if (!req_write)             state_d = S_LOAD;
          else if (req_funct3 == 3'b011)   state_d = S_WRITE;
          else                             state_d = S_RMW_READ;
        end
      end
      S_LOAD: begin
        memoryread = 1'b1;
        address    = base;
        data_d     = load_ext;
        state_d    = S_RESP;
      end
      S_RMW_READ: begin
        memoryread = 1'b1;
        address    = base;
        data_d     = merged;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        memorywrite = 1'b1;
        address     = base;
        write_data  = data_q;
        state_d     = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_fault = fault_q;
        resp_rdata = (fault_q || write_q) ? 64'd0 : data_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      data_q   <= 64'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      fault_q  <= fault_d;
    end
  end

`ifdef LSU_PERF_EN
  logic [31:0] perf_loads_q, perf_loads_d;
  logic [31:0] perf_stores_q, perf_stores_d;
  logic [31:0] perf_faults_q, perf_faults_d;

  always_comb begin
    perf_loads_d  = perf_loads_q;
    perf_stores_d = perf_stores_q;
    perf_faults_d = perf_faults_q;
    if (state_q == S_RESP) begin
      if (fault_q)      perf_faults_d = perf_faults_q + 32'd1;
      else if (write_q) perf_stores_d = perf_stores_q + 32'd1;
      else              perf_loads_d  = perf_loads_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_loads_q  <= 32'd0;
      perf_stores_q <= 32'd0;
      perf_faults_q <= 32'd0;
    end else begin
      perf_loads_q  <= perf_loads_d;
      perf_stores_q <= perf_stores_d;
      perf_faults_q <= perf_faults_d;
    end
  end

  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
  assign perf_faults = perf_faults_q;
`endif

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb/tb_lsu_mem_initiator.sv - bench for lsu_mem_initiator against a byte-array memory model
module tb_lsu_mem_initiator;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic [63:0] address;
  logic [63:0] write_data;
  logic        memorywrite;
  logic        memoryread;
  logic [63:0] read_data;
`ifdef LSU_PERF_EN
  logic [31:0] perf_loads, perf_stores, perf_faults;
`endif

  int checks = 0;
  int errors = 0;
  logic tb_init = 1'b1;
  logic [7:0] mem [0:63];
  logic [7:0] ref_mem [0:63];

  always #5 clk = ~clk;

  lsu_mem_initiator #(.MEM_BYTES(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .address(address), .write_data(write_data), .memorywrite(memorywrite),
    .memoryread(memoryread), .read_data(read_data)
`ifdef LSU_PERF_EN
    , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_faults(perf_faults)
`endif
  );

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'd0;
      mem[0]  <= 8'd6;
      mem[8]  <= 8'd54;
      mem[16] <= 8'd44;
    end else if (memorywrite && address < 64'd64) begin
      for (int i = 0; i < 8; i++) mem[address[5:0] + 6'(i)] <= write_data[8*i +: 8];
    end
  end

  always_comb begin
    read_data = 64'd0;
    for (int i = 0; i < 8; i++)
      if (address + 64'(i) < 64'd64) read_data[8*i +: 8] = mem[address[5:0] + 6'(i)];
  end

  function automatic logic [63:0] exp_load(input logic [2:0] f3, input logic [63:0] a);
    int n = 1 << f3[1:0];
    logic [63:0] v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8 * i));
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  task automatic run_req(input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, output logic [63:0] rd, output logic flt,
                         output int lat, output int nrd, output int nwr,
                         output logic [63:0] raddr, output logic [63:0] wdat);
    int t = 0;
    logic [63:0] base = {a[63:3], 3'b000};
    lat = 0; nrd = 0; nwr = 0; rd = 64'd0; flt = 1'b0; raddr = 64'd0; wdat = 64'd0;
    @(negedge clk);
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_before_accept got=%b exp=1", req_ready); end
    @(posedge clk);
    #1 req_valid = 1'b0; req_wdata = 64'd0; req_addr = 64'd0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (memoryread === 1'b1) begin nrd++; raddr = address; end
      if (memorywrite === 1'b1) begin nwr++; wdat = write_data; end
      if (memoryread === 1'b1 || memorywrite === 1'b1) begin
        checks++;
        if (address !== base) begin errors++; $display("FAIL strobe_address got=%h exp=%h", address, base); end
      end
      if (resp_valid === 1'b1) begin
        lat = n; rd = resp_rdata; flt = resp_fault;
        break;
      end else begin
        checks++;
        if (resp_rdata !== 64'd0 || resp_fault !== 1'b0) begin
          errors++; $display("FAIL resp_idle_zero got rdata=%h fault=%b exp=0", resp_rdata, resp_fault);
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'd0;
    ref_mem[0] = 8'd6; ref_mem[8] = 8'd54; ref_mem[16] = 8'd44;
    reset_n = 1'b0; tb_init = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_fault, memoryread, memorywrite} !== 5'b0 ||
        resp_rdata !== 64'd0 || address !== 64'd0 || write_data !== 64'd0) begin
      errors++; $display("FAIL reset_outputs got ready=%b rv=%b rf=%b rd=%b wr=%b exp all 0",
                         req_ready, resp_valid, resp_fault, memoryread, memorywrite);
    end
`ifdef LSU_PERF_EN
    checks++;
    if (perf_loads !== 0 || perf_stores !== 0 || perf_faults !== 0) begin
      errors++; $display("FAIL reset_perf got %0d/%0d/%0d exp 0", perf_loads, perf_stores, perf_faults);
    end
`endif
    tb_init = 1'b0; reset_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b exp=1", req_ready); end
  endtask

  task automatic test_load_store();
    logic [63:0] rd, ra, wdt; logic f; int lat, nr, nw;
    run_req(1'b0, 3'b011, 64'd8, 64'd0, rd, f, lat, nr, nw, ra, wdt);
    checks++;
    if (rd !== 64'd54 || f !== 1'b0 || lat != 2 || nr != 1 || nw != 0 || ra !== 64'd8) begin
      errors++; $display("FAIL ld8 got rd=%h f=%b lat=%0d nr=%0d nw=%0d ra=%h exp 54/0/2/1/0/8", rd, f, lat, nr, nw, ra);
    end
    run_req(1'b1, 3'b000, 64'd3, 64'hAB, rd, f, lat, nr, nw, ra, wdt);
    ref_mem[3] = 8'hAB;
    checks++;
    if (wdt !== 64'h00000000AB000006 || f !== 1'b0 || lat != 3 || nr != 1 || nw != 1 || ra !== 64'd0 || rd !== 64'd0) begin
      errors++; $display("FAIL sb3 got wd=%h f=%b lat=%0d nr=%0d nw=%0d ra=%h exp AB000006/0/3/1/1/0", wdt, f, lat, nr, nw, ra);
    end
    run_req(1'b0, 3'b011, 64'd0, 64'd0, rd, f, lat, nr, nw, ra, wdt);
    checks++;
    if (rd !== 64'h00000000AB000006) begin errors++; $display("FAIL ld0 got=%h exp=00000000ab000006", rd); end
    run_req(1'b0, 3'b000, 64'd3, 64'd0, rd, f, lat, nr, nw, ra, wdt);
    checks++;
    if (rd !== 64'hFFFFFFFFFFFFFFAB) begin errors++; $display("FAIL lb3 got=%h exp=ffffffffffffffab", rd); end
    run_req(1'b0, 3'b100, 64'd3, 64'd0, rd, f, lat, nr, nw, ra, wdt);
    checks++;
    if (rd !== 64'hAB) begin errors++; $display("FAIL lbu3 got=%h exp=ab", rd); end
    run_req(1'b0, 3'b101, 64'd2, 64'd0, rd, f, lat, nr, nw, ra, wdt);
    checks++;
    if (rd !== 64'hAB00) begin errors++; $display("FAIL lhu2 got=%h exp=ab00", rd); end
  endtask

  task automatic test_faults();
    logic [63:0] rd, ra, wdt; logic f; int lat, nr, nw;
    logic        fw [3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0]  ff [3] = '{3'b010, 3'b011, 3'b100};
    logic [63:0] fa [3] = '{64'd2, 64'd64, 64'd0};
`ifdef LSU_PERF_EN
    logic [31:0] pf0 = perf_faults;
`endif
    for (int k = 0; k < 3; k++) begin
      run_req(fw[k], ff[k], fa[k], 64'hFFFF_FFFF_FFFF_FFFF, rd, f, lat, nr, nw, ra, wdt);
      checks++;
      if (f !== 1'b1 || rd !== 64'd0 || lat != 1 || nr != 0 || nw != 0) begin
        errors++; $display("FAIL fault_case%0d got f=%b rd=%h lat=%0d nr=%0d nw=%0d exp 1/0/1/0/0", k, f, rd, lat, nr, nw);
      end
    end
`ifdef LSU_PERF_EN
    @(negedge clk);
    checks++;
    if (perf_faults - pf0 !== 32'd3) begin errors++; $display("FAIL perf_faults got=%0d exp=3", perf_faults - pf0); end
`endif
  endtask

  task automatic test_reset_mid_write();
    logic [63:0] rd, ra, wdt; logic f; int lat, nr, nw;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b011; req_addr = 64'd16; req_wdata = 64'h1234;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (memorywrite !== 1'b1) begin errors++; $display("FAIL sd_write_strobe got=%b exp=1", memorywrite); end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (memorywrite !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_drops_write got wr=%b ready=%b exp 0/0", memorywrite, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL ready_after_release got ready=%b rv=%b exp 1/0", req_ready, resp_valid);
    end
    run_req(1'b0, 3'b011, 64'd16, 64'd0, rd, f, lat, nr, nw, ra, wdt);
    checks++;
    if (rd !== 64'd44 || f !== 1'b0) begin errors++; $display("FAIL ld16_after_abort got=%h exp=2c", rd); end
  endtask

  task automatic test_back_to_back();
    int acc [2]; int rsp [2]; int na = 0; int nr = 0;
    logic [63:0] got [2];
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b011; req_addr = 64'd8;
    for (int c = 0; c < 20 && nr < 2; c++) begin
      if (resp_valid === 1'b1) begin rsp[nr] = c; got[nr] = resp_rdata; nr++; end
      if (req_valid && req_ready === 1'b1 && na < 2) begin
        acc[na] = c; na++;
        @(posedge clk);
        #1;
        if (na == 1) req_addr = 64'd16; else req_valid = 1'b0;
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
    checks++;
    if (na != 2 || nr != 2) begin
      errors++; $display("FAIL b2b_count got acc=%0d resp=%0d exp 2/2", na, nr);
    end else begin
      checks++;
      if (acc[1] != rsp[0] + 1 || rsp[1] - rsp[0] != 3) begin
        errors++; $display("FAIL b2b_timing got acc2-rsp1=%0d rsp2-rsp1=%0d exp 1/3", acc[1] - rsp[0], rsp[1] - rsp[0]);
      end
      checks++;
      if (got[0] !== exp_load(3'b011, 64'd8) || got[1] !== exp_load(3'b011, 64'd16)) begin
        errors++; $display("FAIL b2b_data got %h %h exp %h %h", got[0], got[1], exp_load(3'b011, 64'd8), exp_load(3'b011, 64'd16));
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] rd, ra, wdt, a, wd, erd, ewd; logic f, w, ef; logic [2:0] f3;
    int lat, nr, nw, n, elat, enr, enw;
    for (int k = 0; k < 120; k++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 71));
      wd = {$urandom, $urandom};
      n  = 1 << f3[1:0];
      ef = (f3 == 3'b111) || (w && f3 >= 3'd4) || ((a % 64'(n)) != 0) || ((a / 8) >= 64'd8);
      erd = 64'd0; ewd = 64'd0; enr = 0; enw = 0;
      if (ef) begin
        elat = 1;
      end else if (!w) begin
        erd = exp_load(f3, a); elat = 2; enr = 1;
      end else begin
        for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
        ewd = exp_load(3'b011, {a[63:3], 3'b000});
        elat = (n == 8) ? 2 : 3; enr = (n == 8) ? 0 : 1; enw = 1;
      end
      run_req(w, f3, a, wd, rd, f, lat, nr, nw, ra, wdt);
      checks++;
      if (rd !== erd || f !== ef || lat != elat || nr != enr || nw != enw || (enw == 1 && wdt !== ewd)) begin
        errors++;
        $display("FAIL random%0d w=%b f3=%0d a=%h got rd=%h f=%b lat=%0d nr=%0d nw=%0d wd=%h exp rd=%h f=%b lat=%0d nr=%0d nw=%0d wd=%h",
                 k, w, f3, a, rd, f, lat, nr, nw, wdt, erd, ef, elat, enr, enw, ewd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_faults();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_mem_initiator.md
# lsu_mem_initiator

Load/store unit driving the byte-addressed, 64-byte data memory from the MEM stage of the pipeline. It accepts one load or store per handshake and decodes RV64 funct3 sizes. Sub-doubleword stores are turned into aligned read-modify-write doubleword transactions, because the memory always writes 8 bytes. Loads are returned sign- or zero-extended, and illegal, misaligned or out-of-range requests are reported as faults.

## Interface
- MEM_BYTES, 64, data memory size in bytes; must be a multiple of 8.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE with reset_n high.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV64 funct3 size/sign code.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data; the low 1/2/4/8 bytes are used.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  64  extended load data; 0 for stores and faults.
- resp_fault  out  1  qualified by resp_valid.
- address  out  64  memory byte address; always 8-aligned when a strobe is high.
- write_data  out  64  memory write data.
- memorywrite  out  1  memory write strobe; memory writes on the clk edge.
- memoryread  out  1  memory read strobe; memory read path is combinational.
- read_data  in  64  memory read data.

## Operation
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- Accept: req_valid && req_ready latches write, funct3, addr and wdata.
- Size codes: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
- Illegal funct3: 111 for any request, and 100–110 for stores.
- Derived values: base = addr & ~7, off = addr[2:0].
- Fault conditions (checked at accept):
  - illegal funct3;
  - addr not a multiple of the access size;
  - base + 8 > MEM_BYTES.
- Accept transitions:
  - fault → RESP with resp_fault=1; no memory strobe at any point.
  - load → LOAD.
  - store d → WRITE.
  - store b/h/w → RMW_READ.
- LOAD: memoryread=1, address=base. Capture read_data >> (8·off), extend to 64 bits, go to RESP.
- RMW_READ: memoryread=1, address=base. Capture read_data with the size bytes at off replaced by the low bytes of wdata, go to WRITE.
- WRITE: memorywrite=1, address=base, write_data = merged or full wdata. Go to RESP.
- RESP: resp_valid=1, go to IDLE.
- Outside LOAD, RMW_READ and WRITE: memoryread=0, memorywrite=0, address=0, write_data=0.

## Timing
- Latency from the accept edge to the resp_valid cycle:
  - fault: 1 cycle;
  - load and SD: 2 cycles;
  - SB/SH/SW: 3 cycles.
- Throughput:
  - no request is accepted while busy or in RESP;
  - the next accept is possible in the cycle after RESP;
  - there is no response backpressure.
- Strobes are decoded combinationally from state. address and write_data are stable for the whole strobe cycle.
- Reset values: state IDLE, req_ready 0, resp_valid 0, resp_rdata 0, resp_fault 0, memoryread 0, memorywrite 0, address 0, write_data 0, all latched request fields 0.
- Reset mid-operation:
  - the state clears immediately, so memorywrite drops before the next edge and no partial write occurs;
  - no response is issued for the aborted request;
  - req_ready=1 in the first cycle with reset_n high.
- resp_rdata and resp_fault hold their values only during resp_valid, and are 0 otherwise.

## Configuration
- LSU_PERF_EN defined:
  - adds outputs perf_loads and perf_stores (32 bits each, reset 0);
  - the matching counter increments in RESP when resp_fault=0, and wraps from 0xFFFFFFFF to 0;
  - adds output perf_faults (32 bits), incremented on every faulted response.
- LSU_PERF_EN undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Memory preloaded with byte 6 at address 0, 54 at 8 and 44 at 16, all other bytes 0. LD 8 → memoryread high exactly 1 cycle with address=8; resp_rdata=64'd54 at accept+2, resp_fault=0.
- SB addr 3, wdata 0xAB → memoryread cycle at address 0, then a memorywrite cycle with write_data=0x00000000AB000006; resp at accept+3. A following LD 0 returns 0x00000000AB000006.
- After the SB: LB 3 → 0xFFFFFFFFFFFFFFAB; LBU 3 → 0xAB; LHU 2 → 0xAB00.
- Fault cases (LW addr 2; SD addr 64; store funct3=100), each → resp_valid with resp_fault=1 at accept+1, resp_rdata=0, no strobe. With LSU_PERF_EN, perf_faults=3.
- SD addr 16, wdata 0x1234, with reset_n pulled low during WRITE before the edge → memorywrite deasserts immediately and a later LD 16 returns 44. req_ready=1 on the first cycle after release.
- req_valid held high for two LD requests → the second accept occurs the cycle after the first resp_valid, and the responses are 3 cycles apart.
